// File: rtl/altpll_pll_if.sv
// Derived-clock bundle between the behavioural PLL and the wrapper that consumes it.
// The PLL drives every signal; the wrapper only observes them.
interface altpll_pll_if;
    logic c0;
    logic c2;
    logic c3;
    logic c4;
    logic locked;

    modport master (output c0, c2, c3, c4, locked);
    modport slave  (input  c0, c2, c3, c4, locked);
endinterface

// File: rtl/altpll_pll.sv
// Behavioural PLL stand-in: integer-divided, phase-offset square waves from inclk0
// plus a sticky lock flag raised after a fixed settling interval.
module altpll_pll #(
    parameter int unsigned DIV0        = 2,
    parameter int unsigned DIV2        = 4,
    parameter int unsigned DIV3        = 5,
    parameter int unsigned DIV4        = 8,
    parameter int unsigned PHASE0      = 0,
    parameter int unsigned PHASE2      = 0,
    parameter int unsigned PHASE3      = 0,
    parameter int unsigned PHASE4      = 0,
    parameter int unsigned LOCK_CYCLES = 16
) (
    input  logic          inclk0,
    input  logic          reset_n,
    altpll_pll_if.master  pll
);

    typedef logic [15:0] cnt_t;

    if (DIV0 < 2 || DIV0 > 65535) begin : g_bad_div0
        $fatal(1, "altpll_pll: DIV0 out of range");
    end
    if (DIV2 < 2 || DIV2 > 65535) begin : g_bad_div2
        $fatal(1, "altpll_pll: DIV2 out of range");
    end
    if (DIV3 < 2 || DIV3 > 65535) begin : g_bad_div3
        $fatal(1, "altpll_pll: DIV3 out of range");
    end
    if (DIV4 < 2 || DIV4 > 65535) begin : g_bad_div4
        $fatal(1, "altpll_pll: DIV4 out of range");
    end
    if (PHASE0 >= DIV0 || PHASE2 >= DIV2 || PHASE3 >= DIV3 || PHASE4 >= DIV4) begin : g_bad_phase
        $fatal(1, "altpll_pll: PHASEk must be below DIVk");
    end
    if (LOCK_CYCLES < 1 || LOCK_CYCLES > 65535) begin : g_bad_lock
        $fatal(1, "altpll_pll: LOCK_CYCLES out of range");
    end

    // High phase is ceil(DIV/2), so odd ratios get the extra cycle high.
    localparam cnt_t LAST0  = cnt_t'(DIV0 - 1);
    localparam cnt_t LAST2  = cnt_t'(DIV2 - 1);
    localparam cnt_t LAST3  = cnt_t'(DIV3 - 1);
    localparam cnt_t LAST4  = cnt_t'(DIV4 - 1);
    localparam cnt_t HIGH0  = cnt_t'(DIV0 - DIV0 / 2);
    localparam cnt_t HIGH2  = cnt_t'(DIV2 - DIV2 / 2);
    localparam cnt_t HIGH3  = cnt_t'(DIV3 - DIV3 / 2);
    localparam cnt_t HIGH4  = cnt_t'(DIV4 - DIV4 / 2);
    localparam cnt_t PH0    = cnt_t'(PHASE0);
    localparam cnt_t PH2    = cnt_t'(PHASE2);
    localparam cnt_t PH3    = cnt_t'(PHASE3);
    localparam cnt_t PH4    = cnt_t'(PHASE4);
    localparam cnt_t LOCK_N = cnt_t'(LOCK_CYCLES);

    function automatic cnt_t wrap_inc(input cnt_t c, input cnt_t last);
        return (c == last) ? '0 : c + 16'd1;
    endfunction

    cnt_t lc;
    cnt_t cnt0, cnt2, cnt3, cnt4;
    logic locked_q;
    logic c0_q, c2_q, c3_q, c4_q;

    cnt_t lc_nxt;
    cnt_t nxt0, nxt2, nxt3, nxt4;

    assign lc_nxt = lc + 16'd1;
    assign nxt0   = wrap_inc(cnt0, LAST0);
    assign nxt2   = wrap_inc(cnt2, LAST2);
    assign nxt3   = wrap_inc(cnt3, LAST3);
    assign nxt4   = wrap_inc(cnt4, LAST4);

    // Divider counters sit at their phase offset until lock, then free-run.
    always_ff @(posedge inclk0) begin
        if (!reset_n) begin
            lc       <= '0;
            locked_q <= 1'b0;
            cnt0     <= PH0;
            cnt2     <= PH2;
            cnt3     <= PH3;
            cnt4     <= PH4;
            c0_q     <= 1'b0;
            c2_q     <= 1'b0;
            c3_q     <= 1'b0;
            c4_q     <= 1'b0;
        end else if (!locked_q) begin
            lc       <= lc_nxt;
            locked_q <= (lc_nxt == LOCK_N);
            cnt0     <= PH0;
            cnt2     <= PH2;
            cnt3     <= PH3;
            cnt4     <= PH4;
            c0_q     <= 1'b0;
            c2_q     <= 1'b0;
            c3_q     <= 1'b0;
            c4_q     <= 1'b0;
        end else begin
            cnt0 <= nxt0;
            cnt2 <= nxt2;
            cnt3 <= nxt3;
            cnt4 <= nxt4;
            c0_q <= (nxt0 < HIGH0);
            c2_q <= (nxt2 < HIGH2);
            c3_q <= (nxt3 < HIGH3);
            c4_q <= (nxt4 < HIGH4);
        end
    end

    assign pll.locked = locked_q;
    assign pll.c0     = c0_q;
    assign pll.c2     = c2_q;
    assign pll.c3     = c3_q;
    assign pll.c4     = c4_q;

endmodule

// File: tb/tb_altpll_pll.sv
// Directed bench for altpll_pll: three instances (defaults, phase-shifted c2,
// fast lock with the widest c4 divide) checked edge by edge against a closed-form model.
module tb_altpll_pll;

    localparam int LOCK_A = 16;

    logic clk = 1'b0;
    logic reset_n;
    logic rst_c;

    always #5 clk = ~clk;

    altpll_pll_if bus_a ();
    altpll_pll_if bus_b ();
    altpll_pll_if bus_c ();

    altpll_pll u_a (
        .inclk0  (clk),
        .reset_n (reset_n),
        .pll     (bus_a)
    );

    altpll_pll #(.PHASE2(2)) u_b (
        .inclk0  (clk),
        .reset_n (reset_n),
        .pll     (bus_b)
    );

    altpll_pll #(.LOCK_CYCLES(1), .DIV4(65535), .PHASE4(32766)) u_c (
        .inclk0  (clk),
        .reset_n (rst_c),
        .pll     (bus_c)
    );

    int checks   = 0;
    int failures = 0;

    logic [4:0] exp_q[$];
    logic [4:0] exp_b_q[$];
    int         runs[$];

    int   rel_ab  = 0;
    int   rel_c   = 0;
    logic c_prev  = 1'b0;
    logic c_start = 1'b0;
    int   run_len = 0;

    // Output after the edge that is the rel-th one sampled with reset released.
    function automatic logic ck_exp(input int rel, input int lock_n, input int d, input int p);
        int j;
        if (rel <= lock_n) return 1'b0;
        j = rel - lock_n;
        return ((p + j) % d) < (d - d / 2);
    endfunction

    function automatic logic [4:0] exp_vec(input int rel, input int p2);
        return {rel >= LOCK_A, ck_exp(rel, LOCK_A, 2, 0), ck_exp(rel, LOCK_A, 4, p2),
                ck_exp(rel, LOCK_A, 5, 0), ck_exp(rel, LOCK_A, 8, 0)};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input logic rn, input logic rnc);
        logic [4:0] ea;
        logic [4:0] eb;
        reset_n = rn;
        rst_c   = rnc;
        rel_ab  = rn  ? rel_ab + 1 : 0;
        rel_c   = rnc ? rel_c + 1  : 0;
        exp_q.push_back(exp_vec(rel_ab, 0));
        exp_b_q.push_back(exp_vec(rel_ab, 2));
        @(posedge clk);
        #1;
        ea = exp_q.pop_front();
        eb = exp_b_q.pop_front();
        check("a_outputs", 32'({bus_a.locked, bus_a.c0, bus_a.c2, bus_a.c3, bus_a.c4}), 32'(ea));
        check("b_outputs", 32'({bus_b.locked, bus_b.c0, bus_b.c2, bus_b.c3, bus_b.c4}), 32'(eb));
        check("c_locked", 32'(bus_c.locked), 32'(rel_c >= 1));
        if (rel_c >= 1 && bus_c.c4 !== c_prev) begin
            if (c_start) runs.push_back(run_len);
            c_start = 1'b1;
            run_len = 1;
        end else begin
            run_len++;
        end
        c_prev = bus_c.c4;
    endtask

    int pat3[5]  = '{1, 1, 0, 0, 1};
    int pat2b[4] = '{0, 1, 1, 0};

    initial begin
        reset_n = 1'b0;
        rst_c   = 1'b0;

        repeat (3) step(1'b0, 1'b0);
        check("reset_a_all_zero", 32'({bus_a.locked, bus_a.c0, bus_a.c2, bus_a.c3, bus_a.c4}), 32'd0);

        for (int i = 1; i <= LOCK_A; i++) begin
            step(1'b1, 1'b1);
            if (i == 1) check("c_lock_first_edge", 32'(bus_c.locked), 32'd1);
            if (i == LOCK_A - 1) check("a_not_locked_15", 32'(bus_a.locked), 32'd0);
        end
        check("a_locked_16", 32'(bus_a.locked), 32'd1);
        check("a_clocks_zero_at_lock", 32'({bus_a.c0, bus_a.c2, bus_a.c3, bus_a.c4}), 32'd0);

        for (int j = 1; j <= 10; j++) begin
            step(1'b1, 1'b1);
            check("c0_pattern", 32'(bus_a.c0), 32'((j % 2) == 0));
            check("c3_pattern", 32'(bus_a.c3), 32'(pat3[(j - 1) % 5]));
            check("b_c2_phase", 32'(bus_b.c2), 32'(pat2b[(j - 1) % 4]));
        end

        repeat (30) step(1'b1, 1'b1);

        step(1'b0, 1'b1);
        check("midreset_a_zero", 32'({bus_a.locked, bus_a.c0, bus_a.c2, bus_a.c3, bus_a.c4}), 32'd0);
        check("midreset_b_zero", 32'({bus_b.locked, bus_b.c0, bus_b.c2, bus_b.c3, bus_b.c4}), 32'd0);

        for (int i = 1; i <= LOCK_A; i++) begin
            step(1'b1, 1'b1);
            if (i == LOCK_A - 1) check("relock_not_yet", 32'(bus_a.locked), 32'd0);
        end
        check("relock_16", 32'(bus_a.locked), 32'd1);

        while (runs.size() < 3 && rel_c < 70000) step(1'b1, 1'b1);
        check("c4_runs_found", 32'(runs.size() >= 3), 32'd1);
        if (runs.size() >= 3) begin
            check("c4_first_high_run", 32'(runs[0]), 32'd1);
            check("c4_low_run", 32'(runs[1]), 32'd32767);
            check("c4_high_run", 32'(runs[2]), 32'd32768);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
